// File: rtl/gray_count_monitor_if.sv
// Bundle between the upstream Gray cascade/readout side and the monitor.
// master drives the sampled digits; slave is the monitor that decodes them.
interface gray_count_monitor_if;
    logic       en;
    logic [3:0] gray_hi;
    logic [3:0] gray_lo;
    logic [7:0] value;
    logic       dir;
    logic       step;
    logic       wrap;
    logic       err;
    logic [7:0] err_cnt;
    logic       locked;

    modport master (
        output en, gray_hi, gray_lo,
        input  value, dir, step, wrap, err, err_cnt, locked
    );

    modport slave (
        input  en, gray_hi, gray_lo,
        output value, dir, step, wrap, err, err_cnt, locked
    );
endinterface

// File: rtl/gray_count_monitor.sv
// Decodes a two-digit Gray count, checks each sampled transition for hold/+-1
// legality and declares lock after LOCK_COUNT consecutive good steps.
module gray_count_monitor #(
    parameter int LOCK_COUNT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    gray_count_monitor_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    state_t     state, state_nxt;
    logic [7:0] value_q, value_d;
    logic       dir_q, dir_d;
    logic       step_q, step_d;
    logic       wrap_q, wrap_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [3:0] good_q, good_d;
    logic       locked_q;

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    logic [7:0] new_val;
    logic       is_hold, is_up, is_dn, is_step, is_ill, is_wrap, lock_hit;

    assign new_val  = {gray2bin(bus.gray_hi), gray2bin(bus.gray_lo)};
    assign is_hold  = (new_val == value_q);
    assign is_up    = (new_val == value_q + 8'd1);
    assign is_dn    = (new_val == value_q - 8'd1);
    assign is_step  = is_up | is_dn;
    assign is_ill   = ~(is_hold | is_step);
    assign is_wrap  = (is_up && value_q == 8'hFF) || (is_dn && value_q == 8'h00);
    assign lock_hit = ((good_q + 4'd1) == 4'(LOCK_COUNT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            value_q   <= 8'd0;
            dir_q     <= 1'b1;
            step_q    <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
            good_q    <= 4'd0;
            locked_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            value_q   <= value_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            good_q    <= good_d;
            locked_q  <= (state_nxt == LOCKED);
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.en) begin
            case (state)
                IDLE:    state_nxt = ACQUIRE;
                ACQUIRE: if (is_step && lock_hit) state_nxt = LOCKED;
                LOCKED:  if (is_ill) state_nxt = ACQUIRE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; pulses default low every cycle.
    always_comb begin
        value_d   = value_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        wrap_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        good_d    = good_q;
        if (bus.en) begin
            if (state == IDLE) begin
                value_d = new_val;
                good_d  = 4'd0;
            end else if (is_step) begin
                value_d = new_val;
                dir_d   = is_up;
                step_d  = 1'b1;
                wrap_d  = is_wrap;
                if (state == ACQUIRE) good_d = good_q + 4'd1;
            end else if (is_ill) begin
                value_d = new_val;
                err_d   = 1'b1;
                good_d  = 4'd0;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    assign bus.value   = value_q;
    assign bus.dir     = dir_q;
    assign bus.step    = step_q;
    assign bus.wrap    = wrap_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.locked  = locked_q;
endmodule

// File: tb/tb_gray_count_monitor.sv
// Scoreboard bench for gray_count_monitor: a behavioural model pushes the
// expected outputs for each driven sample; they are popped after the edge.
module tb_gray_count_monitor;
    localparam int LOCK = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gray_count_monitor_if bus ();
    gray_count_monitor #(.LOCK_COUNT(LOCK)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int value, dir, step, wrap, err, err_cnt, locked;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_state = 0;  // 0 idle, 1 acquire, 2 locked
    int m_value = 0, m_dir = 1, m_good = 0, m_errc = 0;
    int m_step = 0, m_wrap = 0, m_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int g2b(input int g);
        return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
    endfunction

    function automatic logic [7:0] enc(input int v);
        int h, l;
        h = (v >> 4) & 15;
        l = v & 15;
        return 8'((((h ^ (h >> 1)) & 15) << 4) | ((l ^ (l >> 1)) & 15));
    endfunction

    task automatic model(input bit r, input bit e, input logic [7:0] g);
        int nv;
        m_step = 0; m_wrap = 0; m_err = 0;
        if (r) begin
            m_state = 0; m_value = 0; m_dir = 1; m_good = 0; m_errc = 0;
        end else if (e) begin
            nv = g2b(int'(g[7:4])) * 16 + g2b(int'(g[3:0]));
            if (m_state == 0) begin
                m_value = nv; m_good = 0; m_state = 1;
            end else if (nv == m_value) begin
                // hold
            end else if (nv == (m_value + 1) % 256 || nv == (m_value + 255) % 256) begin
                m_step = 1;
                m_dir  = (nv == (m_value + 1) % 256) ? 1 : 0;
                m_wrap = (m_dir == 1 && m_value == 255) || (m_dir == 0 && m_value == 0);
                m_value = nv;
                if (m_state == 1) begin
                    m_good++;
                    if (m_good == LOCK) m_state = 2;
                end
            end else begin
                m_value = nv; m_err = 1; m_good = 0; m_state = 1;
                if (m_errc < 255) m_errc++;
            end
        end
    endtask

    task automatic drive(input bit r, input bit e, input logic [7:0] g);
        exp_t x, y;
        @(negedge clk);
        rst = r;
        bus.en = e;
        bus.gray_hi = g[7:4];
        bus.gray_lo = g[3:0];
        model(r, e, g);
        x.value = m_value; x.dir = m_dir; x.step = m_step; x.wrap = m_wrap;
        x.err = m_err; x.err_cnt = m_errc; x.locked = (m_state == 2);
        q.push_back(x);
        @(posedge clk);
        #1;
        y = q.pop_front();
        chk("value",   int'(bus.value),   y.value);
        chk("dir",     int'(bus.dir),     y.dir);
        chk("step",    int'(bus.step),    y.step);
        chk("wrap",    int'(bus.wrap),    y.wrap);
        chk("err",     int'(bus.err),     y.err);
        chk("err_cnt", int'(bus.err_cnt), y.err_cnt);
        chk("locked",  int'(bus.locked),  y.locked);
    endtask

    task automatic go(input int v);
        drive(1'b0, 1'b1, enc(v));
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom));
    endtask

    initial begin
        bus.en = 1'b0;
        bus.gray_hi = 4'd0;
        bus.gray_lo = 4'd0;

        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'hA5);
        gap(2);

        // lock-up 0..4, then carry 15->16
        for (int v = 0; v <= 16; v++) go(v);
        chk("carry_value", int'(bus.value), 16);
        chk("carry_wrap", int'(bus.wrap), 0);

        // down to 0, wrap to 255, up-wrap back to 0, up to 5
        for (int v = 15; v >= 0; v--) go(v);
        go(255);
        chk("down_wrap", int'(bus.wrap), 1);
        chk("down_dir", int'(bus.dir), 0);
        for (int v = 0; v <= 5; v++) go(v);

        // illegal jump 5->9 then relock over four steps
        go(9);
        chk("jump_locked", int'(bus.locked), 0);
        for (int v = 10; v <= 13; v++) go(v);
        chk("relock", int'(bus.locked), 1);

        // holds and gaps while locked, then in acquire mid-count
        go(13); go(13); go(13);
        gap(3);
        go(50); go(51); go(52);
        go(52); go(52); go(52);
        gap(3);
        go(53);
        chk("acq_not_locked", int'(bus.locked), 0);
        go(54);
        chk("acq_locked", int'(bus.locked), 1);

        // saturation: 260 illegal transitions
        for (int i = 0; i < 260; i++) go((i % 2 == 0) ? 8'h20 : 8'h80);
        chk("sat_cnt", int'(bus.err_cnt), 255);

        // mid-stream reset, then re-entry through idle
        drive(1'b1, 1'b1, enc(100));
        go(100); go(101); go(102);

        // random mix of steps, holds, jumps and gaps
        for (int i = 0; i < 300; i++) begin
            int k, nv;
            k = int'($urandom_range(0, 9));
            nv = (k < 4) ? (m_value + 1) % 256 :
                 (k < 6) ? (m_value + 255) % 256 :
                 (k < 7) ? m_value : int'($urandom_range(0, 255));
            if (k == 9) gap(1);
            else if (i == 150) drive(1'b1, 1'b0, 8'h00);
            else go(nv);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gray_count_monitor.md
# gray_count_monitor

Receive-side companion to the one-digit Gray counter chain. It samples a two-digit (hi/lo) Gray-coded count from an upstream cascade and decodes it to an 8-bit binary value. Each sampled transition is checked for legality (hold or ±1 modulo 256). The block reports direction, step and wrap events, and keeps a saturating error count. It sits between the counter cascade and the display/readout logic and declares the stream trustworthy only after a run of good steps.

## Interface
- LOCK_COUNT, 4: consecutive legal ±1 steps needed to go from ACQUIRE to LOCKED (1..15).
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high; has priority over every other input.
- en  input  1  sample strobe; gray_hi/gray_lo are sampled only when en=1.
- gray_hi  input  4  upstream high digit, standard reflected Gray code.
- gray_lo  input  4  upstream low digit, standard reflected Gray code.
- value  output  8  last accepted binary count, hi*16+lo.
- dir  output  1  direction of the last legal step (1=up, 0=down).
- step  output  1  one-cycle pulse on a legal ±1 step.
- wrap  output  1  one-cycle pulse on a legal 255→0 or 0→255 step.
- err  output  1  one-cycle pulse on an illegal transition.
- err_cnt  output  8  saturating count of illegal transitions.
- locked  output  1  high while in state LOCKED.

## Operation
- Per-digit decode: b3=g3, b2=b3^g2, b1=b2^g1, b0=b1^g0. new = {dec(gray_hi), dec(gray_lo)}.
- Classification applies only when en=1 and state≠IDLE:
  - HOLD: new==value.
  - UP: new==value+1 mod 256.
  - DOWN: new==value−1 mod 256.
  - Anything else is ILLEGAL.
- States are IDLE, ACQUIRE and LOCKED. An internal good_cnt (4 bits) tracks progress toward lock.
- IDLE:
  - en=1: value←new, good_cnt←0, go to ACQUIRE. No pulses are produced.
  - en=0: stay in IDLE.
- ACQUIRE:
  - UP/DOWN: value←new, dir←(UP), step=1, wrap=1 if the step crosses 255↔0, good_cnt+1. When good_cnt+1==LOCK_COUNT, go to LOCKED.
  - HOLD: no change, no pulses, good_cnt unchanged.
  - ILLEGAL: value←new, err=1, err_cnt+1 (saturating at 255), good_cnt←0. dir is unchanged.
- LOCKED:
  - UP/DOWN/HOLD: same updates as in ACQUIRE. good_cnt is not used.
  - ILLEGAL: value←new, err=1, err_cnt+1 (saturating), good_cnt←0, go to ACQUIRE.
- en=0 in any state: all registers hold and step/wrap/err are 0.
- step, wrap and err are mutually exclusive. wrap=1 implies step=1.

## Timing
- Reset values: state IDLE, value=0, dir=1, step=0, wrap=0, err=0, err_cnt=0, locked=0, good_cnt=0.
- Latency: inputs sampled on rising edge N (en=1) are reflected in value/dir/step/wrap/err/err_cnt/locked after edge N. Outputs are registered, so there are no combinational paths from input to output.
- locked rises on the same edge that completes the LOCK_COUNT-th good step, and falls on the edge that detects an ILLEGAL transition.
- Pulses are exactly one cycle wide. Back-to-back en=1 cycles may produce pulses on consecutive cycles.
- Reset mid-operation: on the next edge with rst=1 everything returns to reset values, including err_cnt and any pending pulse. The first en=1 sample after reset re-enters through IDLE.
- err_cnt at 255 stays at 255. err still pulses.
- Inputs must be stable around the rising edge. The block performs no synchronization.

## Test plan
- Lock-up: rst, then en=1 with hi=0000 and lo Gray codes of 0,1,2,3,4 on consecutive cycles. Required: value 0..4, step on samples 2–5, dir=1, locked=1 after the 5th sample (LOCK_COUNT=4), err never asserted.
- Digit carry: while locked at value=15 (hi=0000, lo=1000), present hi=0001, lo=0000. Required: value=16, step=1, wrap=0, err=0.
- Down wrap: while locked at value=0, present hi=1000, lo=1000. Required: value=255, dir=0, step=1, wrap=1.
- Illegal jump: while locked at value=5, present the code for 9 (hi=0000, lo=1101). Required: err=1, err_cnt=1, locked=0 and state ACQUIRE, value=9. Four further UP steps relock.
- Hold and gaps: repeat the same sample for 3 cycles, then hold en=0 for 3 cycles with garbage on the inputs. Required: no step/err pulses, value/good_cnt/locked unchanged.
- Saturation and reset: force 256 illegal transitions. Required: err_cnt=255 and err still pulses. Then assert rst mid-stream for one cycle: all outputs return to reset values on that edge.
